// File: rtl/store_write_buffer.sv
// store_write_buffer: turns 32-bit register stores into lane-formatted
// byte/half/word memory writes. It rejects misaligned requests, holds
// aligned writes in a DEPTH-entry FIFO, and drains them in order over a
// valid/ready handshake.
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [31:0]              st_data,
    input  logic [1:0]               st_size,
    output logic                     st_misalign,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // entry storage; contents only matter while counted as occupied
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [3:0]        be_q   [DEPTH];

    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q, count_d;
    logic          misalign_q;

    logic        misal;
    logic [31:0] fmt_data;
    logic [3:0]  fmt_be;
    logic        accept, enq, pop;

    // classify the request and build replicated data and byte enables
    always_comb begin
        misal    = 1'b0;
        fmt_data = st_data;
        fmt_be   = 4'b1111;
        case (st_size)
            2'b00: begin
                fmt_data = {4{st_data[7:0]}};
                fmt_be   = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                misal    = st_addr[0];
                fmt_data = {2{st_data[15:0]}};
                fmt_be   = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                misal    = (st_addr[1:0] != 2'b00);
            end
            default: begin
                misal    = 1'b1;
            end
        endcase
    end

    assign st_ready = rst_n & (count_q != CW'(DEPTH));
    assign accept   = st_valid & st_ready;
    assign enq      = accept & ~misal;
    assign mem_valid = (count_q != '0);
    assign pop      = mem_valid & mem_ready;

    // occupancy: enq and pop together leave it unchanged
    always_comb begin
        count_d = count_q;
        if (enq && !pop)
            count_d = count_q + CW'(1);
        else if (!enq && pop)
            count_d = count_q - CW'(1);
    end

    // pointers, occupancy and the rejection pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (enq) wr_q <= wr_q + PW'(1);
            if (pop) rd_q <= rd_q + PW'(1);
            count_q    <= count_d;
            misalign_q <= accept & misal;
        end
    end

    // write the formatted entry at the tail; no reset needed on payload
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_q] <= {st_addr[ADDR_W-1:2], 2'b00};
            data_q[wr_q] <= fmt_data;
            be_q[wr_q]   <= fmt_be;
        end
    end

    assign mem_addr    = mem_valid ? addr_q[rd_q] : '0;
    assign mem_wdata   = mem_valid ? data_q[rd_q] : '0;
    assign mem_be      = mem_valid ? be_q[rd_q]   : '0;
    assign st_misalign = misalign_q;
    assign count       = count_q;
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer (DEPTH=4, ADDR_W=32).
module tb_store_write_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        st_misalign;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [2:0]  count;

    int errs   = 0;
    int checks = 0;

    store_write_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_size(st_size), .st_misalign(st_misalign),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .count(count)
    );

    always #5 clk = ~clk;

    // advance past a rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1; st_addr = a; st_data = d; st_size = s;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st_valid = 1'b0; mem_ready = 1'b0;
        st_addr = '0; st_data = '0; st_size = '0;
        tick(); tick();
        checks++; if (st_ready !== 1'b0) begin errs++; $display("FAIL rst_ready got=%b exp=0", st_ready); end
        checks++; if (count !== 3'd0) begin errs++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (mem_valid !== 1'b0) begin errs++; $display("FAIL rst_mvalid got=%b exp=0", mem_valid); end
        checks++; if (st_misalign !== 1'b0) begin errs++; $display("FAIL rst_misal got=%b exp=0", st_misalign); end
        checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'd0) begin errs++; $display("FAIL rst_mem got=%h/%h/%b exp=0", mem_addr, mem_wdata, mem_be); end
        rst_n = 1'b1; #1;
        checks++; if (st_ready !== 1'b1) begin errs++; $display("FAIL rst_release_ready got=%b exp=1", st_ready); end
    endtask

    task automatic test_byte();
        push(32'h1003, 32'h000000A5, 2'b00);
        checks++; if (count !== 3'd1 || mem_valid !== 1'b1) begin errs++; $display("FAIL byte_lat got=%0d/%b exp=1/1", count, mem_valid); end
        checks++; if (mem_addr !== 32'h1000) begin errs++; $display("FAIL byte_addr got=%h exp=00001000", mem_addr); end
        checks++; if (mem_wdata !== 32'hA5A5A5A5) begin errs++; $display("FAIL byte_data got=%h exp=a5a5a5a5", mem_wdata); end
        checks++; if (mem_be !== 4'b1000) begin errs++; $display("FAIL byte_be got=%b exp=1000", mem_be); end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        checks++; if (count !== 3'd0 || mem_valid !== 1'b0 || mem_addr !== 32'h0) begin errs++; $display("FAIL byte_pop got=%0d/%b/%h exp=0/0/0", count, mem_valid, mem_addr); end
        push(32'h1101, 32'h12345677, 2'b00);
        checks++; if (mem_be !== 4'b0010 || mem_wdata !== 32'h77777777) begin errs++; $display("FAIL byte1 got=%b/%h exp=0010/77777777", mem_be, mem_wdata); end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    endtask

    task automatic test_half();
        push(32'h2002, 32'hFFFF1234, 2'b01);
        checks++; if (mem_addr !== 32'h2000) begin errs++; $display("FAIL half_addr got=%h exp=00002000", mem_addr); end
        checks++; if (mem_wdata !== 32'h12341234) begin errs++; $display("FAIL half_data got=%h exp=12341234", mem_wdata); end
        checks++; if (mem_be !== 4'b1100) begin errs++; $display("FAIL half_be got=%b exp=1100", mem_be); end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        push(32'h2004, 32'h0000BEEF, 2'b01);
        checks++; if (mem_be !== 4'b0011 || mem_addr !== 32'h2004) begin errs++; $display("FAIL half_lo got=%b/%h exp=0011/00002004", mem_be, mem_addr); end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    endtask

    task automatic test_misalign();
        push(32'h3001, 32'hCAFEF00D, 2'b10);
        checks++; if (st_misalign !== 1'b1) begin errs++; $display("FAIL mis_word got=%b exp=1", st_misalign); end
        checks++; if (count !== 3'd0 || mem_valid !== 1'b0) begin errs++; $display("FAIL mis_noenq got=%0d/%b exp=0/0", count, mem_valid); end
        tick();
        checks++; if (st_misalign !== 1'b0) begin errs++; $display("FAIL mis_pulse got=%b exp=0", st_misalign); end
        push(32'h3003, 32'h1, 2'b01);
        checks++; if (st_misalign !== 1'b1 || count !== 3'd0) begin errs++; $display("FAIL mis_half got=%b/%0d exp=1/0", st_misalign, count); end
        push(32'h3000, 32'h1, 2'b11);
        checks++; if (st_misalign !== 1'b1 || count !== 3'd0) begin errs++; $display("FAIL mis_rsvd got=%b/%0d exp=1/0", st_misalign, count); end
        tick();
    endtask

    task automatic test_full();
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            st_valid = 1'b1; st_addr = 32'h100 + 32'(4*i); st_data = 32'hD0 + 32'(i); st_size = 2'b10;
            if (i == 4) begin
                checks++; if (st_ready !== 1'b0) begin errs++; $display("FAIL full_ready got=%b exp=0", st_ready); end
            end
            tick();
        end
        checks++; if (count !== 3'd4) begin errs++; $display("FAIL full_count got=%0d exp=4", count); end
        tick();
        checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hD0 || mem_be !== 4'b1111) begin errs++; $display("FAIL full_hold got=%h/%h/%b exp=00000100/000000d0/1111", mem_addr, mem_wdata, mem_be); end
        mem_ready = 1'b1;
        tick();
        checks++; if (st_ready !== 1'b1 || mem_addr !== 32'h104 || count !== 3'd3) begin errs++; $display("FAIL full_free got=%b/%h/%0d exp=1/00000104/3", st_ready, mem_addr, count); end
        tick();
        st_valid = 1'b0;
        for (int j = 2; j < 5; j++) begin
            checks++; if (mem_addr !== 32'h100 + 32'(4*j) || mem_wdata !== 32'hD0 + 32'(j)) begin errs++; $display("FAIL full_order%0d got=%h/%h exp=%h/%h", j, mem_addr, mem_wdata, 32'h100 + 32'(4*j), 32'hD0 + 32'(j)); end
            tick();
        end
        mem_ready = 1'b0;
        checks++; if (count !== 3'd0 || mem_valid !== 1'b0) begin errs++; $display("FAIL full_drain got=%0d/%b exp=0/0", count, mem_valid); end
    endtask

    task automatic test_back_to_back();
        push(32'h400, 32'hA, 2'b10);
        push(32'h404, 32'hB, 2'b10);
        st_valid = 1'b1; st_addr = 32'h408; st_data = 32'hC; st_size = 2'b10; mem_ready = 1'b1;
        tick();
        st_valid = 1'b0;
        checks++; if (count !== 3'd2) begin errs++; $display("FAIL b2b_count got=%0d exp=2", count); end
        checks++; if (mem_addr !== 32'h404 || mem_wdata !== 32'hB) begin errs++; $display("FAIL b2b_head got=%h/%h exp=00000404/0000000b", mem_addr, mem_wdata); end
        tick();
        checks++; if (mem_addr !== 32'h408 || mem_wdata !== 32'hC) begin errs++; $display("FAIL b2b_next got=%h/%h exp=00000408/0000000c", mem_addr, mem_wdata); end
        tick();
        mem_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errs++; $display("FAIL b2b_drain got=%0d exp=0", count); end
    endtask

    task automatic test_reset_mid();
        push(32'h600, 32'h61, 2'b10);
        push(32'h604, 32'h62, 2'b10);
        push(32'h608, 32'h63, 2'b10);
        checks++; if (count !== 3'd3) begin errs++; $display("FAIL rmid_pre got=%0d exp=3", count); end
        rst_n = 1'b0;
        tick();
        checks++; if (count !== 3'd0 || mem_valid !== 1'b0 || st_ready !== 1'b0) begin errs++; $display("FAIL rmid_clear got=%0d/%b/%b exp=0/0/0", count, mem_valid, st_ready); end
        rst_n = 1'b1;
        push(32'h5000, 32'h55, 2'b10);
        checks++; if (count !== 3'd1 || mem_addr !== 32'h5000 || mem_wdata !== 32'h55) begin errs++; $display("FAIL rmid_fresh got=%0d/%h/%h exp=1/00005000/00000055", count, mem_addr, mem_wdata); end
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        checks++; if (count !== 3'd0 || mem_valid !== 1'b0) begin errs++; $display("FAIL rmid_stale got=%0d/%b exp=0/0", count, mem_valid); end
    endtask

    initial begin
        test_reset();
        test_byte();
        test_half();
        test_misalign();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
